// File: rtl/ckm_cipher_pkg.sv
// Shared definitions for the chaotic-map stream cipher key/IV front end.
package ckm_cipher_pkg;

    localparam int CKM_KEY_W     = 189;
    localparam int CKM_IV_W      = 32;
    localparam int CKM_IN_W      = 32;
    localparam int CKM_NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ZERO   = 2'd3
    } kv_state_e;

    // Number of load words needed to carry one {key,iv} pair.
    function automatic int n_words(input int key_w, input int iv_w, input int in_w);
        return (key_w + iv_w + in_w - 1) / in_w;
    endfunction

endpackage

// File: rtl/kv_word_shifter.sv
// Serial word collector for one {key,iv} pair: shifts words in MSW first and
// counts them. Only the DATA_W bits that survive into a slot are kept, so the
// excess MSBs of the first word fall off the top as later words arrive.
module kv_word_shifter #(
    parameter int IN_W    = 32,
    parameter int DATA_W  = 221,
    parameter int N_WORDS = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [IN_W-1:0]   data_i,
    output logic [DATA_W-1:0] sreg_o,
    output logic              last_o
);

    localparam int               CNT_W    = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next shift-register contents and word count; clear wins over shift.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            sreg_d = {sreg_q[DATA_W-IN_W-1:0], data_i};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Register the shift chain and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sreg_o = sreg_q;
    assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/key_iv_slot_loader.sv
// Key/IV slot store: serial loading into a shadow shifter, one-cycle commit
// into the slot array, registered read port and a one-slot-per-cycle zeroize.
//
// state  | meaning
// IDLE   | waiting for load_start
// LOAD   | accepting load words (in_ready=1)
// COMMIT | writing the collected pair into slot wslot_q
// ZERO   | clearing slot zidx_q, one per cycle
module key_iv_slot_loader
    import ckm_cipher_pkg::*;
#(
    parameter  int KEY_W     = CKM_KEY_W,
    parameter  int IV_W      = CKM_IV_W,
    parameter  int IN_W      = CKM_IN_W,
    parameter  int NUM_SLOTS = CKM_NUM_SLOTS,
    localparam int SLOT_W    = $clog2(NUM_SLOTS),
    localparam int N_WORDS   = n_words(KEY_W, IV_W, IN_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              read0,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic              zeroize,
    output logic [KEY_W-1:0]  key_o,
    output logic [IV_W-1:0]   iv_o,
    output logic              kv_valid,
    output logic              rd_err,
    output logic              busy
);

    localparam int                KV_W      = KEY_W + IV_W;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    kv_state_e            state_q;
    logic                 in_ready_q, busy_q;
    logic [SLOT_W-1:0]    wslot_q, zidx_q;
    logic [KV_W-1:0]      slot_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic [KEY_W-1:0]     key_q;
    logic [IV_W-1:0]      iv_q;
    logic                 kv_valid_q, rd_err_q;

    logic [KV_W-1:0]      sreg;
    logic [KV_W-1:0]      rd_pair;
    logic                 last_word;
    logic                 ld_ok, accept, sh_clear, sh_shift, rd_go, rd_hit;

    // Request qualification shared by the FSM, shifter and read port.
    always_comb begin
        ld_ok    = load_start && (32'(wr_slot) < NUM_SLOTS);
        accept   = in_valid && in_ready_q;
        sh_clear = !zeroize && ld_ok && (state_q == ST_IDLE || state_q == ST_LOAD);
        sh_shift = !zeroize && (state_q == ST_LOAD) && !ld_ok && accept;
        rd_go    = read0 && !zeroize && (state_q != ST_ZERO);
        rd_hit   = (32'(rd_slot) < NUM_SLOTS) && slot_valid_q[rd_slot];
        rd_pair  = slot_q[rd_slot];
    end

    kv_word_shifter #(
        .IN_W    (IN_W),
        .DATA_W  (KV_W),
        .N_WORDS (N_WORDS)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (sh_clear),
        .shift_i (sh_shift),
        .data_i  (in_data),
        .sreg_o  (sreg),
        .last_o  (last_word)
    );

    // Sequencing FSM with registered in_ready/busy; zeroize overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            wslot_q    <= '0;
            zidx_q     <= '0;
        end else if (zeroize) begin
            state_q    <= ST_ZERO;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            zidx_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ld_ok) begin
                        state_q    <= ST_LOAD;
                        wslot_q    <= wr_slot;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_ok) begin
                        wslot_q <= wr_slot;
                    end else if (sh_shift && last_word) begin
                        state_q    <= ST_COMMIT;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_ZERO: begin
                    if (zidx_q == LAST_SLOT) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        zidx_q <= zidx_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Slot array: a slot only changes at COMMIT or during the zeroize sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            slot_valid_q <= '0;
        end else if (state_q == ST_ZERO) begin
            slot_q[zidx_q]       <= '0;
            slot_valid_q[zidx_q] <= 1'b0;
        end else if (state_q == ST_COMMIT && !zeroize) begin
            slot_q[wslot_q]       <= sreg;
            slot_valid_q[wslot_q] <= 1'b1;
        end
    end

    // Read port: outputs hold between reads; a miss pulses rd_err for one cycle.
    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            key_q      <= '0;
            iv_q       <= '0;
            kv_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else if (rd_go) begin
            if (rd_hit) begin
                key_q      <= rd_pair[KV_W-1:IV_W];
                iv_q       <= rd_pair[IV_W-1:0];
                kv_valid_q <= 1'b1;
                rd_err_q   <= 1'b0;
            end else begin
                kv_valid_q <= 1'b0;
                rd_err_q   <= 1'b1;
            end
        end else begin
            rd_err_q <= 1'b0;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign key_o    = key_q;
    assign iv_o     = iv_q;
    assign kv_valid = kv_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_key_iv_slot_loader.sv
// Scoreboard bench for key_iv_slot_loader: the driver pushes expected read
// responses from a slot-level model, a monitor pops them one cycle after each read.
module tb_key_iv_slot_loader;

    localparam int KEY_W = 189;
    localparam int IV_W  = 32;
    localparam int IN_W  = 32;
    localparam int NS    = 4;
    localparam int NW    = 7;

    logic              clk = 1'b0;
    logic              reset, load_start, in_valid, in_ready, read0, zeroize;
    logic [1:0]        wr_slot, rd_slot;
    logic [IN_W-1:0]   in_data;
    logic [KEY_W-1:0]  key_o;
    logic [IV_W-1:0]   iv_o;
    logic              kv_valid, rd_err, busy;

    always #5 clk = ~clk;

    key_iv_slot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .wr_slot    (wr_slot),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .read0      (read0),
        .rd_slot    (rd_slot),
        .zeroize    (zeroize),
        .key_o      (key_o),
        .iv_o       (iv_o),
        .kv_valid   (kv_valid),
        .rd_err     (rd_err),
        .busy       (busy)
    );

    typedef struct packed {
        logic             kv;
        logic             err;
        logic [KEY_W-1:0] key;
        logic [IV_W-1:0]  iv;
    } rsp_t;

    rsp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;

    logic [KEY_W-1:0] m_key [NS];
    logic [IV_W-1:0]  m_iv  [NS];
    bit               m_val [NS];
    logic [KEY_W-1:0] o_key = '0;
    logic [IV_W-1:0]  o_iv  = '0;
    logic [IN_W-1:0]  words [NW];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a read seen at an edge must be answered by the outputs of that edge.
    initial begin : monitor
        logic rd_seen;
        rsp_t e;
        forever begin
            @(posedge clk);
            rd_seen = read0 && !reset;
            @(negedge clk);
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected kv_valid=%0b rd_err=%0b", kv_valid, rd_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_kv_valid", kv_valid, e.kv);
                    chk("rd_err", rd_err, e.err);
                    chk("rd_key", key_o, e.key);
                    chk("rd_iv", iv_o, e.iv);
                end
            end else begin
                chk("rd_err_idle", rd_err, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Pair as stored in a slot: words placed MSW first, top bits beyond key+iv dropped.
    function automatic logic [KEY_W+IV_W-1:0] pack_words();
        logic [NW*IN_W-1:0] big;
        big = '0;
        for (int i = 0; i < NW; i++) big[(NW-1-i)*IN_W +: IN_W] = words[i];
        return big[KEY_W+IV_W-1:0];
    endfunction

    task automatic gen_words(input bit fix_last);
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        if (fix_last) words[NW-1] = 32'hC33CB332;
    endtask

    // Called at a negedge: drive a read and push its expected response.
    task automatic issue_read(input logic [1:0] s);
        rsp_t e;
        read0   = 1'b1;
        rd_slot = s;
        if (m_val[s]) begin
            o_key = m_key[s];
            o_iv  = m_iv[s];
            e.kv  = 1'b1;
            e.err = 1'b0;
        end else begin
            e.kv  = 1'b0;
            e.err = 1'b1;
        end
        e.key = o_key;
        e.iv  = o_iv;
        exp_q.push_back(e);
    endtask

    task automatic do_read(input logic [1:0] s);
        @(negedge clk);
        load_start = 1'b0; in_valid = 1'b0; zeroize = 1'b0;
        issue_read(s);
        @(posedge clk);
        @(negedge clk);
        read0 = 1'b0;
    endtask

    task automatic start_load(input logic [1:0] s);
        @(negedge clk);
        load_start = 1'b1; wr_slot = s; in_valid = 1'b0; read0 = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_words(input int first, input int n, input bit toggle);
        for (int i = first; i < first + n; i++) begin
            if (toggle) begin
                @(negedge clk);
                load_start = 1'b0; in_valid = 1'b0; read0 = 1'b0;
                chk("busy_gap", busy, 1);
                chk("in_ready_gap", in_ready, 1);
                @(posedge clk);
            end
            @(negedge clk);
            load_start = 1'b0; read0 = 1'b0; in_valid = 1'b1; in_data = words[i];
            chk("busy_load", busy, 1);
            chk("in_ready_load", in_ready, 1);
            @(posedge clk);
        end
    endtask

    task automatic finish_commit(input logic [1:0] s, input bit rd, input logic [1:0] rs);
        @(negedge clk);
        in_valid = 1'b0; load_start = 1'b0; read0 = 1'b0;
        chk("commit_in_ready", in_ready, 0);
        chk("commit_busy", busy, 1);
        if (rd) issue_read(rs);
        @(posedge clk);
        {m_key[s], m_iv[s]} = pack_words();
        m_val[s] = 1'b1;
        @(negedge clk);
        read0 = 1'b0;
        chk("idle_busy", busy, 0);
    endtask

    task automatic full_load(input logic [1:0] s, input bit toggle, input bit rd, input logic [1:0] rs);
        gen_words(1'b0);
        start_load(s);
        send_words(0, NW, toggle);
        finish_commit(s, rd, rs);
    endtask

    initial begin : driver
        logic [1:0] s;
        reset = 1'b1; load_start = 1'b0; wr_slot = '0; in_data = '0; in_valid = 1'b0;
        read0 = 1'b0; rd_slot = '0; zeroize = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_val[i] = 1'b0; m_key[i] = '0; m_iv[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_kv_valid", kv_valid, 0);
        chk("rst_key", key_o, 0);
        chk("rst_iv", iv_o, 0);
        reset = 1'b0;

        // empty slot read after reset
        do_read(2'd0);

        // load slot2 with a known last word
        gen_words(1'b1);
        start_load(2'd2);
        send_words(0, NW, 1'b0);
        finish_commit(2'd2, 1'b0, 2'd0);
        do_read(2'd2);
        chk("iv_known_word", iv_o, 32'hC33CB332);

        // throttled load into slot0
        full_load(2'd0, 1'b1, 1'b0, 2'd0);
        do_read(2'd0);

        // slot1 = A, then an aborted reload of slot1 redirected to slot3
        full_load(2'd1, 1'b0, 1'b0, 2'd0);
        gen_words(1'b0);
        start_load(2'd1);
        send_words(0, 3, 1'b0);
        full_load(2'd3, 1'b0, 1'b0, 2'd0);
        do_read(2'd1);
        do_read(2'd3);

        // read during the COMMIT cycle of the same slot sees the old pair
        full_load(2'd1, 1'b0, 1'b1, 2'd1);
        do_read(2'd1);

        // randomized mix of loads, commit-cycle reads and mid-load reads
        for (int n = 0; n < 12; n++) begin
            s = 2'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 2))
                0: full_load(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             2'($urandom_range(0, NS - 1)));
                1: do_read(s);
                default: begin
                    gen_words(1'b0);
                    start_load(s);
                    send_words(0, 3, 1'b0);
                    do_read(s);
                    send_words(3, NW - 3, 1'b0);
                    finish_commit(s, 1'b0, 2'd0);
                    do_read(s);
                end
            endcase
        end

        // all slots loaded, then zeroize during a load (beats a load_start)
        for (int i = 0; i < NS; i++) full_load(2'(i), 1'b0, 1'b0, 2'd0);
        gen_words(1'b0);
        start_load(2'd2);
        send_words(0, 2, 1'b0);
        @(negedge clk);
        zeroize = 1'b1; in_valid = 1'b0; read0 = 1'b0; load_start = 1'b1; wr_slot = 2'd1;
        @(posedge clk);
        for (int i = 0; i < NS; i++) m_val[i] = 1'b0;
        o_key = '0;
        o_iv  = '0;
        @(negedge clk);
        zeroize = 1'b0; load_start = 1'b0;
        chk("zero_kv_valid", kv_valid, 0);
        chk("zero_key", key_o, 0);
        chk("zero_iv", iv_o, 0);
        chk("zero_in_ready", in_ready, 0);
        for (int i = 0; i < NS; i++) begin
            if (i > 0) @(negedge clk);
            chk("zero_busy", busy, 1);
        end
        @(negedge clk);
        chk("zero_done_busy", busy, 0);
        for (int i = 0; i < NS; i++) do_read(2'(i));

        // loader still works after a sweep
        full_load(2'd0, 1'b0, 1'b0, 2'd0);
        do_read(2'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
